multi_channel_capture: RTL and testbench

Parametrised N-channel ADC capture engine sitting between the per-channel SPI receivers and the UART/FFT consumers. Aligns per-channel sample strobes into sample sets and stores them in a pre-trigger ring buffer. Fires on a threshold crossing on any masked channel, or on a forced trigger. After a configurable post-trigger count it streams one frozen frame out over a valid/ready interface, oldest set first. It replaces the fixed two-channel ring-buffer pair in the top level.

---
 rtl/capture_pkg.sv | 24 ++
 rtl/capture_ring_ram.sv | 40 ++++
 rtl/multi_channel_capture.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_multi_channel_capture.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// capture_pkg
//   Shared definitions for the multi-channel capture engine: the capture FSM
//   state encoding and width helpers derived from the top-level parameters.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        READOUT = 3'd4
    } cap_state_e;

    // Address width of the ring buffer (DEPTH is a power of two).
    function automatic int capture_addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int capture_ch_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/capture_ring_ram.sv
// capture_ring_ram
//   Simple dual-port RAM holding one sample set per row. One write port and
//   one registered read port (1-cycle latency), written to infer block RAM.
//   Ports:
//     clk      system clock
//     we_i     write enable
//     waddr_i  write row address
//     wdata_i  write row data
//     re_i     read enable; rdata_o updates on the following edge
//     raddr_i  read row address
//     rdata_o  registered read data
module capture_ring_ram #(
    parameter int ROW_W  = 40,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [ROW_W-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [ROW_W-1:0]  rdata_o
);

    logic [ROW_W-1:0] mem_q [0:DEPTH-1];
    logic [ROW_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/multi_channel_capture.sv
// multi_channel_capture
//   N-channel ADC capture engine. Per-channel sample strobes are assembled
//   into sample sets and written into a pre-trigger ring buffer. A threshold
//   crossing on a masked channel (or a forced trigger) freezes the frame after
//   a post-trigger count, which is then streamed out oldest set first.
//   Ports:
//     clk, reset_b        clock, asynchronous active-low reset
//     sample_in           packed channel samples, channel c at [c*SAMPLE_W +: SAMPLE_W]
//     sample_valid        per-channel one-cycle data strobes
//     threshold           trigger level (unsigned)
//     trigger_mask        channels allowed to trigger
//     arm                 start a capture (accepted in IDLE only)
//     force_trigger       software trigger (accepted in ARMED only)
//     out_tdata/tuser     sample word and its channel index
//     out_tvalid/tready   stream handshake
//     out_tlast           last word of the frame
//     busy                engine not idle
//     triggered           trigger seen, frame not yet fully drained
//     set_overrun         sticky: a channel strobed twice within one set
module multi_channel_capture
    import capture_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 10,
    parameter int DEPTH    = 1024,
    parameter int PRE_TRIG = 256
) (
    input  logic                              clk,
    input  logic                              reset_b,
    input  logic [NUM_CH*SAMPLE_W-1:0]        sample_in,
    input  logic [NUM_CH-1:0]                 sample_valid,
    input  logic [SAMPLE_W-1:0]               threshold,
    input  logic [NUM_CH-1:0]                 trigger_mask,
    input  logic                              arm,
    input  logic                              force_trigger,
    output logic [SAMPLE_W-1:0]               out_tdata,
    output logic [capture_ch_w(NUM_CH)-1:0]   out_tuser,
    output logic                              out_tvalid,
    input  logic                              out_tready,
    output logic                              out_tlast,
    output logic                              busy,
    output logic                              triggered,
    output logic                              set_overrun
);

    localparam int ADDR_W    = capture_addr_w(DEPTH);
    localparam int CH_W      = capture_ch_w(NUM_CH);
    localparam int ROW_W     = NUM_CH * SAMPLE_W;
    localparam int POST_ROWS = DEPTH - PRE_TRIG;
    localparam int CNT_W     = ADDR_W + 1;

    // ------------------------------------------------------------------
    // Set assembly
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] pend_q, pend_d, pend_all;
    logic [ROW_W-1:0]  hold_q, row_now;
    logic              commit, ovr_now, hit;

    // The committed row merges this cycle's strobes over the holding
    // register, so the channel that completes a set is included directly.
    always_comb begin
        pend_all = pend_q | sample_valid;
        commit   = &pend_all;
        ovr_now  = |(pend_q & sample_valid);
        pend_d   = commit ? '0 : pend_all;
        row_now  = hold_q;
        hit      = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sample_valid[c]) begin
                row_now[c*SAMPLE_W +: SAMPLE_W] = sample_in[c*SAMPLE_W +: SAMPLE_W];
            end
            if (trigger_mask[c] && (row_now[c*SAMPLE_W +: SAMPLE_W] >= threshold)) begin
                hit = 1'b1;
            end
        end
        hit = hit & commit;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= row_now;
    end

    // ------------------------------------------------------------------
    // Capture FSM and write pointer
    // ------------------------------------------------------------------
    cap_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovr_q, ovr_d;
    logic              we;
    logic              pop, last_pop;

    always_comb begin
        we       = commit && ((state_q == FILL) || (state_q == ARMED) || (state_q == POST));
        state_d  = state_q;
        wr_ptr_d = we ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q | ovr_now;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d  = FILL;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                    ovr_d    = ovr_now;
                end
            end
            FILL: begin
                if (we) begin
                    if (cnt_q == CNT_W'(PRE_TRIG - 1)) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ARMED: begin
                // A hit row is itself post-row 1; a bare force waits for
                // the next commit to become post-row 1.
                if (we && hit) begin
                    state_d = (POST_ROWS == 1) ? READOUT : POST;
                    cnt_d   = CNT_W'(1);
                end else if (force_trigger) begin
                    state_d = POST;
                    cnt_d   = '0;
                end
            end
            POST: begin
                if (we) begin
                    if (cnt_q == CNT_W'(POST_ROWS - 1)) begin
                        state_d = READOUT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            READOUT: begin
                if (last_pop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
        end
    end

    // ------------------------------------------------------------------
    // Ring RAM
    // ------------------------------------------------------------------
    logic              issue, issue_last;
    logic [ADDR_W-1:0] rd_off_q, rd_off_d;
    logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
    logic              rd_done_q, rd_done_d;
    logic [ADDR_W-1:0] raddr;
    logic [ROW_W-1:0]  rdata;

    // wr_ptr is frozen during readout and points at the oldest row.
    assign raddr = wr_ptr_q + rd_off_q;

    capture_ring_ram #(
        .ROW_W  (ROW_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (row_now),
        .re_i    (issue),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // ------------------------------------------------------------------
    // Readout: one RAM read per word, then a 2-entry output buffer
    // ------------------------------------------------------------------
    logic                infl_q;
    logic [CH_W-1:0]     infl_ch_q;
    logic                infl_last_q;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d, level;
    logic [SAMPLE_W-1:0] push_data;
    logic [SAMPLE_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [CH_W-1:0]     head_user_q, head_user_d, tail_user_q, tail_user_d;
    logic                head_last_q, head_last_d, tail_last_q, tail_last_d;
    logic                tvalid_q;

    assign pop      = tvalid_q && out_tready;
    assign last_pop = pop && head_last_q;

    // Words in the buffer plus the one in flight from the RAM must never
    // exceed two, counting the slot freed by this cycle's pop.
    always_comb begin
        level      = fifo_cnt_q + {1'b0, infl_q};
        issue      = (state_q == READOUT) && !rd_done_q && (level < (pop ? 2'd3 : 2'd2));
        issue_last = (rd_ch_q == CH_W'(NUM_CH - 1)) && (rd_off_q == ADDR_W'(DEPTH - 1));
        rd_off_d   = rd_off_q;
        rd_ch_d    = rd_ch_q;
        rd_done_d  = rd_done_q;
        if (state_q != READOUT) begin
            rd_off_d  = '0;
            rd_ch_d   = '0;
            rd_done_d = 1'b0;
        end else if (issue) begin
            if (rd_ch_q == CH_W'(NUM_CH - 1)) begin
                rd_ch_d  = '0;
                rd_off_d = rd_off_q + 1'b1;
                if (issue_last) begin
                    rd_done_d = 1'b1;
                end
            end else begin
                rd_ch_d = rd_ch_q + 1'b1;
            end
        end
    end

    always_comb begin
        push_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (infl_ch_q == CH_W'(c)) begin
                push_data = rdata[c*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    always_comb begin
        fifo_cnt_d  = fifo_cnt_q;
        head_data_d = head_data_q;
        head_user_d = head_user_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_user_d = tail_user_q;
        tail_last_d = tail_last_q;
        if (pop) begin
            if (fifo_cnt_q == 2'd2) begin
                head_data_d = tail_data_q;
                head_user_d = tail_user_q;
                head_last_d = tail_last_q;
                if (infl_q) begin
                    tail_data_d = push_data;
                    tail_user_d = infl_ch_q;
                    tail_last_d = infl_last_q;
                end else begin
                    fifo_cnt_d = 2'd1;
                end
            end else if (infl_q) begin
                head_data_d = push_data;
                head_user_d = infl_ch_q;
                head_last_d = infl_last_q;
            end else begin
                // Drained: park the outputs at zero.
                fifo_cnt_d  = 2'd0;
                head_data_d = '0;
                head_user_d = '0;
                head_last_d = 1'b0;
            end
        end else if (infl_q) begin
            if (fifo_cnt_q == 2'd0) begin
                head_data_d = push_data;
                head_user_d = infl_ch_q;
                head_last_d = infl_last_q;
                fifo_cnt_d  = 2'd1;
            end else begin
                tail_data_d = push_data;
                tail_user_d = infl_ch_q;
                tail_last_d = infl_last_q;
                fifo_cnt_d  = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rd_off_q    <= '0;
            rd_ch_q     <= '0;
            rd_done_q   <= 1'b0;
            infl_q      <= 1'b0;
            infl_ch_q   <= '0;
            infl_last_q <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            tvalid_q    <= 1'b0;
            head_data_q <= '0;
            head_user_q <= '0;
            head_last_q <= 1'b0;
        end else begin
            rd_off_q    <= rd_off_d;
            rd_ch_q     <= rd_ch_d;
            rd_done_q   <= rd_done_d;
            infl_q      <= issue;
            infl_ch_q   <= rd_ch_q;
            infl_last_q <= issue_last;
            fifo_cnt_q  <= fifo_cnt_d;
            tvalid_q    <= (fifo_cnt_d != 2'd0);
            head_data_q <= head_data_d;
            head_user_q <= head_user_d;
            head_last_q <= head_last_d;
        end
    end

    always_ff @(posedge clk) begin
        tail_data_q <= tail_data_d;
        tail_user_q <= tail_user_d;
        tail_last_q <= tail_last_d;
    end

    assign out_tdata   = head_data_q;
    assign out_tuser   = head_user_q;
    assign out_tlast   = head_last_q;
    assign out_tvalid  = tvalid_q;
    assign busy        = (state_q != IDLE);
    assign triggered   = (state_q == POST) || (state_q == READOUT);
    assign set_overrun = ovr_q;

endmodule

// File: tb/tb_multi_channel_capture.sv
module tb_multi_channel_capture;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 10;
    localparam int DEPTH    = 16;
    localparam int PRE_TRIG = 4;
    localparam int ROW_W    = NUM_CH * SAMPLE_W;

    logic              clk;
    logic              reset_b;
    logic [ROW_W-1:0]  sample_in;
    logic [NUM_CH-1:0] sample_valid;
    logic [SAMPLE_W-1:0] threshold;
    logic [NUM_CH-1:0] trigger_mask;
    logic              arm;
    logic              force_trigger;
    logic [SAMPLE_W-1:0] out_tdata;
    logic [1:0]        out_tuser;
    logic              out_tvalid;
    logic              out_tready;
    logic              out_tlast;
    logic              busy;
    logic              triggered;
    logic              set_overrun;

    multi_channel_capture #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH),
        .PRE_TRIG (PRE_TRIG)
    ) dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .threshold     (threshold),
        .trigger_mask  (trigger_mask),
        .arm           (arm),
        .force_trigger (force_trigger),
        .out_tdata     (out_tdata),
        .out_tuser     (out_tuser),
        .out_tvalid    (out_tvalid),
        .out_tready    (out_tready),
        .out_tlast     (out_tlast),
        .busy          (busy),
        .triggered     (triggered),
        .set_overrun   (set_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [SAMPLE_W-1:0] data;
        logic [1:0]          ch;
        logic                last;
    } exp_t;

    exp_t             exp_q[$];
    int               checks   = 0;
    int               errors   = 0;
    int               word_cnt = 0;
    bit               bp_mode  = 1'b0;
    logic [ROW_W-1:0] rows [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Channel c of set k carries 16k+c.
    function automatic logic [ROW_W-1:0] mkrow(input int k);
        logic [ROW_W-1:0] r;
        for (int c = 0; c < NUM_CH; c++) begin
            r[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(16 * k + c);
        end
        return r;
    endfunction

    task automatic build_rows(input int n);
        for (int k = 0; k < n; k++) rows[k] = mkrow(k);
    endtask

    task automatic push_frame(input int first);
        exp_t e;
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                e.data = rows[first + r][c*SAMPLE_W +: SAMPLE_W];
                e.ch   = 2'(c);
                e.last = (r == DEPTH - 1) && (c == NUM_CH - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic strobe(input logic [NUM_CH-1:0] m, input logic [ROW_W-1:0] row);
        @(posedge clk); #1;
        sample_in    = row;
        sample_valid = m;
        @(posedge clk); #1;
        sample_valid = '0;
    endtask

    task automatic send_range(input int a, input int b);
        for (int k = a; k <= b; k++) strobe(4'hF, rows[k]);
    endtask

    task automatic do_arm();
        @(posedge clk); #1;
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({name, "_idle"}, busy, 0);
        check({name, "_trig_low"}, triggered, 0);
        check({name, "_words_left"}, exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_tvalid"}, out_tvalid, 0);
        check({name, "_tlast"}, out_tlast, 0);
        check({name, "_tdata"}, out_tdata, 0);
        check({name, "_tuser"}, out_tuser, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_triggered"}, triggered, 0);
        check({name, "_overrun"}, set_overrun, 0);
    endtask

    // Consumer ready: always high, or high 30% of cycles under backpressure.
    initial begin
        out_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_tready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: handshake decided at the coming posedge is observed at negedge.
    initial begin
        exp_t        e;
        bit          stall;
        logic [12:0] held;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!reset_b) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                check("stall_valid_held", out_tvalid, 1);
                check("stall_word_stable", {out_tdata, out_tuser, out_tlast}, held);
            end
            if (out_tvalid && out_tready) begin
                word_cnt++;
                stall = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0d required=none", out_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", out_tdata, e.data);
                    check("word_chan", out_tuser, e.ch);
                    check("word_last", out_tlast, e.last);
                end
            end else if (out_tvalid) begin
                stall = 1'b1;
                held  = {out_tdata, out_tuser, out_tlast};
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ROW_W-1:0] r18;
        reset_b       = 1'b0;
        sample_in     = '0;
        sample_valid  = '0;
        threshold     = 10'd600;
        trigger_mask  = 4'b0010;
        arm           = 1'b0;
        force_trigger = 1'b0;
        #12;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        reset_b = 1'b1;

        // Basic capture: hit at set 20, frame = sets 16..31.
        build_rows(32);
        rows[20][19:10] = 10'd700;
        push_frame(16);
        do_arm();
        check("basic_busy", busy, 1);
        send_range(0, 19);
        check("basic_pre_trig", triggered, 0);
        send_range(20, 20);
        check("basic_trig", triggered, 1);
        send_range(21, 31);
        wait_idle("basic");

        // Hit during FILL ignored; hit at set 30 -> frame 26..41.
        build_rows(42);
        rows[2][19:10]  = 10'd700;
        rows[30][19:10] = 10'd700;
        push_frame(26);
        do_arm();
        send_range(0, 29);
        check("fill_hit_ignored", triggered, 0);
        send_range(30, 30);
        check("late_hit_trig", triggered, 1);
        send_range(31, 41);
        wait_idle("ignored");

        // Overrun: ch2 strobes twice inside set 18; second value (999) kept.
        build_rows(32);
        rows[20][19:10] = 10'd700;
        r18 = rows[18];
        rows[18][29:20] = 10'd999;
        push_frame(16);
        do_arm();
        check("overrun_clear_start", set_overrun, 0);
        send_range(0, 17);
        strobe(4'b0111, r18);
        check("overrun_not_yet", set_overrun, 0);
        strobe(4'b0100, rows[18]);
        check("overrun_set", set_overrun, 1);
        strobe(4'b1000, rows[18]);
        send_range(19, 31);
        wait_idle("overrun");
        check("overrun_sticky", set_overrun, 1);

        // Unmasked channel ignored; force after set 9 -> frame 6..21.
        build_rows(22);
        rows[6][9:0] = 10'd1000;
        push_frame(6);
        do_arm();
        check("arm_clears_overrun", set_overrun, 0);
        send_range(0, 9);
        check("mask_no_trig", triggered, 0);
        @(posedge clk); #1;
        force_trigger = 1'b1;
        @(posedge clk); #1;
        force_trigger = 1'b0;
        check("force_trig", triggered, 1);
        send_range(10, 21);
        wait_idle("force");

        // Backpressure: same frame as the basic run.
        build_rows(32);
        rows[20][19:10] = 10'd700;
        push_frame(16);
        bp_mode = 1'b1;
        do_arm();
        send_range(0, 31);
        wait_idle("backpressure");
        bp_mode = 1'b0;

        // Reset in the middle of readout, then a full re-capture.
        push_frame(16);
        word_cnt = 0;
        do_arm();
        send_range(0, 31);
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (word_cnt >= 20) break;
        end
        check("reached_word20", (word_cnt >= 20), 1);
        #1;
        reset_b = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_outputs_zero("midreset");
        @(posedge clk); #1;
        reset_b = 1'b1;
        push_frame(16);
        do_arm();
        send_range(0, 31);
        wait_idle("rearm");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
